tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Shares one free-running prescaler among 4 independent timer channels.
- Each channel emits single-cycle enable ticks (TICK) at a programmable multiple of the base period. Ticks are clock enables, not derived clocks.
- Replaces per-consumer divider counters: display scan, debounce, the 1 Hz game timer and buzzer pacing all consume TICK bits in the CLK domain.
- Configured through a single-cycle write port. Each channel is either periodic or one-shot.

Parameters:
- PRESCALE, 50000: CLK cycles per base strobe (50 MHz gives 1 kHz); must be ≥ 2.
- DIV_W, 16: width of the per-channel divisor and counter.
- N_CH, 4: number of channels; fixed at 4 in this revision, CFG_CH is 2 bits.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset
- CFG_WE  in  1  configuration write strobe, accepted every cycle (no backpressure)
- CFG_CH  in  2  target channel
- CFG_DIV  in  DIV_W  base strobes per tick; 0 means disable
- CFG_MODE  in  1  0 = periodic, 1 = one-shot
- CFG_EN  in  1  1 = start/restart the channel, 0 = stop it
- BASE_TICK  out  1  registered copy of the base strobe
- TICK  out  N_CH  per-channel tick pulse, one cycle wide
- BUSY  out  N_CH  channel in RUN
- DONE  out  N_CH  one-shot completed, sticky

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. All counters are 0 and all channels IDLE. BASE_TICK=0, TICK=0, BUSY=0, DONE=0. Stored DIV and MODE are 0.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps. It is free-running and never affected by CFG writes.
  - Internal strobe stb is high in a cycle where pcnt==PRESCALE-1.
  - BASE_TICK is high in the following cycle, so it asserts once per PRESCALE cycles and is exactly 1 cycle wide.
- Channel FSM, per channel: states IDLE, RUN, DONE.
  - Write with CFG_EN=1 and CFG_DIV≠0, from any state: latch DIV/MODE, ccnt←0, go to RUN, clear DONE.
  - Write with CFG_EN=0 or CFG_DIV=0, from any state: go to IDLE, ccnt←0, clear DONE.
  - RUN on stb:
    - If ccnt==DIV-1: ccnt←0 and TICK[i]=1 in the next cycle. MODE=0 stays in RUN; MODE=1 goes to DONE.
    - Otherwise ccnt←ccnt+1.
  - DONE: holds until the next write to that channel. No ticks are issued.
- Timing:
  - TICK[i] and BASE_TICK rise on the same edge.
  - The first tick after an enabling write corresponds to the DIV-th stb strictly after the write cycle. A stb in the write cycle itself is ignored for that channel.
- Status outputs are registered from state: BUSY[i] = (state==RUN) and DONE[i] = (state==DONE). Both are valid the cycle after the causing edge.
- Simultaneous write and stb on the same channel: the write wins. The counter reloads and no TICK is issued.
- Other channels are unaffected by a write; ticks on several channels in the same cycle are allowed.
- DIV=1 gives a tick on every stb.
- Counters are DIV_W wide, compare-and-clear, no overflow path.
- RST mid-count: everything returns immediately to reset values and any pending tick is lost.

Decomposition:
- Shared package holds:
  - channel state encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - mode constants: MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1
  - default PRESCALE for the 50 MHz board
- One sub-module is natural: tick_channel, holding the per-channel FSM, counter, DIV/MODE registers and TICK/BUSY/DONE flops. The top holds the prescaler and write decode and instantiates tick_channel N_CH times.

Test Plan (PRESCALE=4 for simulation):
- Release RST, no writes → BASE_TICK is a 1-cycle pulse every 4 cycles. TICK, BUSY and DONE stay 0.
- Write ch0 DIV=3, MODE=0, EN=1 → BUSY[0]=1. TICK[0] pulses on the 3rd, 6th and 9th BASE_TICK after the write, each coincident with BASE_TICK and 1 cycle wide.
- Write ch1 DIV=2, MODE=1 → exactly one TICK[1] on the 2nd BASE_TICK. Then BUSY[1]=0, DONE[1]=1, held for 40 cycles. A rewrite with EN=1 clears DONE[1] and restarts.
- Write ch2 DIV=1 in the cycle where stb is high → no TICK[2] from that stb. TICK[2] appears on every subsequent BASE_TICK.
- Write ch0 EN=0 mid-count, and separately write ch3 with DIV=0 → channel goes IDLE, BUSY=0, no further ticks.
- Assert RST asynchronously while ch0 is at ccnt=2 of DIV=3 → all outputs 0 before the next CLK edge. After release there are no ticks until reconfigured.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler_pkg
//  Purpose  : Shared channel-state encoding, mode constants and board default
//             prescale for the tick scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // 50 MHz board clock divided down to a 1 kHz base strobe
    localparam int DEFAULT_PRESCALE = 50000;

endpackage
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tick_channel
//  Purpose  : One timer channel: counts base strobes, emits one-cycle tick
//             enables, periodic or one-shot, with registered status flags.
//  Revision : 1.0  initial release
// ============================================================================
module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_mode,
    input  logic             wr_en,
    input  logic             stb,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    ch_state_t        state, state_nxt;
    logic [DIV_W-1:0] ccnt, ccnt_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             mode_q, mode_nxt;
    logic             tick_nxt;

    // Next-state and datapath: a write always beats a coincident strobe
    always_comb begin
        state_nxt = state;
        ccnt_nxt  = ccnt;
        div_nxt   = div_q;
        mode_nxt  = mode_q;
        tick_nxt  = 1'b0;
        if (wr) begin
            ccnt_nxt = '0;
            if (wr_en && (wr_div != '0)) begin
                state_nxt = ST_RUN;
                div_nxt   = wr_div;
                mode_nxt  = wr_mode;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else if ((state == ST_RUN) && stb) begin
            if (ccnt == (div_q - DIV_W'(1))) begin
                ccnt_nxt = '0;
                tick_nxt = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_nxt = ST_DONE;
                end
            end else begin
                ccnt_nxt = ccnt + DIV_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter and latched configuration
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ccnt   <= '0;
            div_q  <= '0;
            mode_q <= MODE_PERIODIC;
        end else begin
            ccnt   <= ccnt_nxt;
            div_q  <= div_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Output flops: tick aligned with BASE_TICK, status registered from state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            tick <= tick_nxt;
            busy <= (state == ST_RUN);
            done <= (state == ST_DONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler
//  Purpose  : Free-running prescaler shared by N_CH timer channels that issue
//             single-cycle clock-enable ticks at multiples of the base period.
//  Revision : 1.0  initial release
// ============================================================================
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int DIV_W    = 16,
    parameter int N_CH     = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_CH,
    input  logic [DIV_W-1:0] CFG_DIV,
    input  logic             CFG_MODE,
    input  logic             CFG_EN,
    output logic             BASE_TICK,
    output logic [N_CH-1:0]  TICK,
    output logic [N_CH-1:0]  BUSY,
    output logic [N_CH-1:0]  DONE
);

    localparam int              PW        = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          stb;

    assign stb = (pcnt == PCNT_LAST);

    // Free-running prescaler, untouched by configuration writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt <= '0;
        end else if (stb) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Base strobe delayed one cycle so it lines up with channel ticks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BASE_TICK <= 1'b0;
        end else begin
            BASE_TICK <= stb;
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic wr;
            assign wr = CFG_WE && (CFG_CH == 2'(i));

            tick_channel #(
                .DIV_W (DIV_W)
            ) u_ch (
                .CLK     (CLK),
                .RST     (RST),
                .wr      (wr),
                .wr_div  (CFG_DIV),
                .wr_mode (CFG_MODE),
                .wr_en   (CFG_EN),
                .stb     (stb),
                .tick    (TICK[i]),
                .busy    (BUSY[i]),
                .done    (DONE[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_scheduler
//  Purpose  : Self-checking bench for tick_scheduler with a countdown-based
//             behavioural model, directed scenarios and random configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PRESCALE = 4;
    localparam int DIV_W    = 16;
    localparam int N_CH     = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CFG_WE = 1'b0;
    logic [1:0]       CFG_CH = '0;
    logic [DIV_W-1:0] CFG_DIV = '0;
    logic             CFG_MODE = 1'b0;
    logic             CFG_EN = 1'b0;
    logic             BASE_TICK;
    logic [N_CH-1:0]  TICK, BUSY, DONE;

    tick_scheduler #(
        .PRESCALE (PRESCALE),
        .DIV_W    (DIV_W),
        .N_CH     (N_CH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CFG_WE    (CFG_WE),
        .CFG_CH    (CFG_CH),
        .CFG_DIV   (CFG_DIV),
        .CFG_MODE  (CFG_MODE),
        .CFG_EN    (CFG_EN),
        .BASE_TICK (BASE_TICK),
        .TICK      (TICK),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: cycle position within the base period, and per channel
    // the number of strobes still to go before the next tick.
    int             m_phase;
    bit             m_act  [N_CH];
    bit             m_done [N_CH];
    int             m_rem  [N_CH];
    int             m_div  [N_CH];
    bit             m_mode [N_CH];
    logic           e_base;
    logic [N_CH-1:0] e_tick, e_busy, e_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_rem[i]  = 0;
            m_div[i]  = 0;
            m_mode[i] = 1'b0;
        end
    endtask

    // One clock cycle: present inputs, predict, clock, compare
    task automatic step(input bit we, input int ch, input int div, input bit mode, input bit en);
        bit stb;
        stb      = (m_phase == PRESCALE - 1);
        CFG_WE   = we;
        CFG_CH   = ch[1:0];
        CFG_DIV  = div[DIV_W-1:0];
        CFG_MODE = mode;
        CFG_EN   = en;
        e_base   = stb;
        for (int i = 0; i < N_CH; i++) begin
            e_busy[i] = m_act[i];
            e_done[i] = m_done[i];
            e_tick[i] = 1'b0;
            if (we && ch == i) begin
                m_done[i] = 1'b0;
                if (en && div != 0) begin
                    m_act[i]  = 1'b1;
                    m_div[i]  = div;
                    m_mode[i] = mode;
                    m_rem[i]  = div;
                end else begin
                    m_act[i] = 1'b0;
                end
            end else if (m_act[i] && stb) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    e_tick[i] = 1'b1;
                    if (m_mode[i]) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_rem[i] = m_div[i];
                    end
                end
            end
        end
        m_phase = (m_phase + 1) % PRESCALE;
        @(posedge CLK);
        #1;
        CFG_WE = 1'b0;
        check("base_tick", 32'(BASE_TICK), 32'(e_base));
        check("tick",      32'(TICK),      32'(e_tick));
        check("busy",      32'(BUSY),      32'(e_busy));
        check("done",      32'(DONE),      32'(e_done));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_base", 32'(BASE_TICK), 32'd0);
        check("rst_tick", 32'(TICK), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RST = 1'b0;

        // Quiet prescaler
        idle(12);

        // Periodic channel 0, divisor 3
        step(1'b1, 0, 3, 1'b0, 1'b1);
        idle(40);

        // One-shot channel 1, divisor 2, then sticky done and restart
        step(1'b1, 1, 2, 1'b1, 1'b1);
        idle(50);
        step(1'b1, 1, 2, 1'b1, 1'b1);
        idle(14);

        // Channel 2 divisor 1 written in the strobe cycle
        for (int k = 0; k < PRESCALE && m_phase != PRESCALE - 1; k++) idle(1);
        check("stb_align", 32'(m_phase), 32'(PRESCALE - 1));
        step(1'b1, 2, 1, 1'b0, 1'b1);
        idle(12);

        // Stop channel 0 by EN=0, channel 3 by DIV=0
        step(1'b1, 0, 3, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 3, 5, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 3, 0, 1'b0, 1'b1);
        idle(24);

        // Async reset while channel 0 sits at count 2 of divisor 3
        step(1'b1, 0, 3, 1'b0, 1'b1);
        for (int k = 0; k < 40 && m_rem[0] != 1; k++) idle(1);
        check("ccnt2_reached", 32'(m_rem[0]), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_base", 32'(BASE_TICK), 32'd0);
        check("arst_tick", 32'(TICK), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_done", 32'(DONE), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        idle(20);

        // Random configuration traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            end else begin
                idle(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
